// File: rtl/test_runner_pkg.sv
// Shared definitions for the fixture sequencer: state encodings, blink gap
// multiplier and the fixture index width helper.
package test_runner_pkg;

   typedef enum logic [2:0] {
      ST_WAIT = 3'd0,
      ST_ARM  = 3'd1,
      ST_BUSY = 3'd2,
      ST_NEXT = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Dark gap between blink groups, in units of one blink phase.
   localparam int GAP_MULT = 4;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/blink_code.sv
// Red blink code: i_count blinks (on/off phases of BLINK_CYCLES each), then a
// GAP_MULT*BLINK_CYCLES dark gap, repeating while i_en is high.
module blink_code
   import test_runner_pkg::*;
#(
   parameter int BLINK_CYCLES = 6_000_000,
   parameter int IDX_W        = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [IDX_W:0]   i_count,
   output logic             o_led
);

   localparam int GAP_CYCLES = GAP_MULT * BLINK_CYCLES;
   localparam int CNT_W      = $clog2(GAP_CYCLES) + 1;
   localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W:0]   n_blinks;
   logic             active;
   logic             in_gap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_led    <= 1'b0;
         cnt      <= '0;
         n_blinks <= '0;
         active   <= 1'b0;
         in_gap   <= 1'b0;
      end else if (!i_en) begin
         o_led    <= 1'b0;
         cnt      <= '0;
         n_blinks <= '0;
         active   <= 1'b0;
         in_gap   <= 1'b0;
      end else if (!active) begin
         // First enabled cycle opens with an on-phase.
         active <= 1'b1;
         o_led  <= 1'b1;
         cnt    <= '0;
      end else if (o_led) begin
         if (cnt == PH_LAST) begin
            o_led <= 1'b0;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (in_gap) begin
         if (cnt == GAP_LAST) begin
            in_gap <= 1'b0;
            o_led  <= 1'b1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (cnt == PH_LAST) begin
         cnt <= '0;
         if (n_blinks + 1'b1 == i_count) begin
            n_blinks <= '0;
            in_gap   <= 1'b1;
         end else begin
            n_blinks <= n_blinks + 1'b1;
            o_led    <= 1'b1;
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/test_runner.sv
// On-board fixture sequencer: start-up delay, then runs each fixture through a
// run/running/passed handshake and reports the outcome on the RGB LED lines.
module test_runner
   import test_runner_pkg::*;
#(
   parameter int N_TESTS        = 4,
   parameter int STARTUP_CYCLES = 64,
   parameter int TIMEOUT_CYCLES = 2**20,
   parameter int BLINK_CYCLES   = 6_000_000,
   parameter int STOP_ON_FAIL   = 1,
   localparam int IDX_W         = idx_w(N_TESTS)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   output logic [N_TESTS-1:0] o_run,
   input  logic [N_TESTS-1:0] i_running,
   input  logic [N_TESTS-1:0] i_passed,
   output logic               o_done,
   output logic               o_all_passed,
   output logic [N_TESTS-1:0] o_pass_mask,
   output logic               o_timeout,
   output logic [IDX_W-1:0]   o_fail_idx,
   output logic               o_led_r,
   output logic               o_led_g,
   output logic               o_led_b
);

   localparam int WAIT_W = $clog2(STARTUP_CYCLES) + 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARTUP_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]  K_LAST    = IDX_W'(N_TESTS - 1);

   state_t             state, state_n;
   logic [IDX_W-1:0]   k, k_n;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               any_fail;
   logic               fail_now, tmo_now, pass_now;
   logic               tmo_hit;
   logic [N_TESTS-1:0] run_n;
   logic [IDX_W:0]     blink_count;
   logic               blink_en;

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_comb begin
      state_n  = state;
      k_n      = k;
      fail_now = 1'b0;
      tmo_now  = 1'b0;
      pass_now = 1'b0;
      case (state)
         ST_WAIT: if (wait_cnt == WAIT_LAST) begin
            state_n = ST_ARM;
            k_n     = '0;
         end
         ST_ARM: begin
            if (tmo_hit) begin
               state_n  = ST_NEXT;
               fail_now = 1'b1;
               tmo_now  = 1'b1;
            end else if (i_running[k]) begin
               state_n = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Timeout takes priority over a completion in the same cycle.
            if (tmo_hit) begin
               state_n  = ST_NEXT;
               fail_now = 1'b1;
               tmo_now  = 1'b1;
            end else if (!i_running[k]) begin
               state_n  = ST_NEXT;
               pass_now = i_passed[k];
               fail_now = !i_passed[k];
            end
         end
         ST_NEXT: begin
            if (k == K_LAST || (any_fail && STOP_ON_FAIL != 0)) begin
               state_n = ST_DONE;
            end else begin
               k_n     = k + 1'b1;
               state_n = ST_ARM;
            end
         end
         ST_DONE: state_n = ST_DONE;
         default: state_n = ST_WAIT;
      endcase
   end

   always_comb begin
      run_n = '0;
      if (state_n == ST_ARM || state_n == ST_BUSY) run_n[k_n] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= ST_WAIT;
         k            <= '0;
         wait_cnt     <= '0;
         tmo_cnt      <= '0;
         any_fail     <= 1'b0;
         o_run        <= '0;
         o_done       <= 1'b0;
         o_all_passed <= 1'b0;
         o_pass_mask  <= '0;
         o_timeout    <= 1'b0;
         o_fail_idx   <= '0;
         o_led_g      <= 1'b0;
         o_led_b      <= 1'b0;
      end else begin
         state <= state_n;
         k     <= k_n;
         if (state_n == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (state_n == ST_ARM && state != ST_ARM)
            tmo_cnt <= '0;
         else if (state_n == ST_ARM || state_n == ST_BUSY)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (pass_now) o_pass_mask[k] <= 1'b1;
         if (fail_now) begin
            any_fail <= 1'b1;
            if (!any_fail) begin
               o_fail_idx <= k;
               o_timeout  <= tmo_now;
            end
         end
         o_run        <= run_n;
         o_done       <= (state_n == ST_DONE);
         o_all_passed <= (state_n == ST_DONE) && !(any_fail || fail_now);
         o_led_g      <= (state_n == ST_DONE) && !(any_fail || fail_now);
         o_led_b      <= (state_n == ST_ARM) || (state_n == ST_BUSY) ||
                         (state_n == ST_NEXT);
      end
   end

   // Enable tracks the next state so the first DONE cycle already shows red.
   assign blink_en    = (state_n == ST_DONE) && (any_fail || fail_now);
   assign blink_count = {1'b0, o_fail_idx} + 1'b1;

   blink_code #(
      .BLINK_CYCLES (BLINK_CYCLES),
      .IDX_W        (IDX_W)
   ) u_blink (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (blink_en),
      .i_count (blink_count),
      .o_led   (o_led_r)
   );

endmodule

// File: tb/tb_test_runner.sv
// Directed bench: two sequencers (halt-on-fail and run-all) driven by
// behavioural fixture models, checked against hand-computed outcomes.
module tb_test_runner;

   localparam int M_NORM  = 0;
   localparam int M_NEVER = 1;
   localparam int M_IMM   = 2;

   logic clk;
   logic rst_n;

   // Index 0: STOP_ON_FAIL=1, index 1: STOP_ON_FAIL=0
   logic [1:0][2:0] run, running, passed, pass_mask, ever;
   logic [1:0][1:0] fail_idx;
   logic [1:0]      done, all_passed, timeout, led_r, led_g, led_b;
   logic [1:0][2:0] fcnt, fdone;

   int         mode [3];
   logic [2:0] pcfg;
   int         checks = 0;
   int         errors = 0;

   logic [2:0] trun  [0:63];
   logic [2:0] tmask [0:63];
   logic       tdone [0:63];
   logic       tledb [0:63];
   logic       tledg [0:63];
   logic       ttmo  [0:63];

   typedef struct {
      bit         stop;
      int         m0, m1, m2;
      logic [2:0] pcfg;
      logic       exp_all;
      logic [2:0] exp_mask;
      logic       exp_tmo;
      logic [1:0] exp_idx;
      logic [2:0] exp_ever;
   } vec_t;

   vec_t vecs [7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   test_runner #(.N_TESTS(3), .STARTUP_CYCLES(4), .TIMEOUT_CYCLES(16),
                 .BLINK_CYCLES(2), .STOP_ON_FAIL(1)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .o_run(run[0]), .i_running(running[0]),
      .i_passed(passed[0]), .o_done(done[0]), .o_all_passed(all_passed[0]),
      .o_pass_mask(pass_mask[0]), .o_timeout(timeout[0]), .o_fail_idx(fail_idx[0]),
      .o_led_r(led_r[0]), .o_led_g(led_g[0]), .o_led_b(led_b[0]));

   test_runner #(.N_TESTS(3), .STARTUP_CYCLES(4), .TIMEOUT_CYCLES(16),
                 .BLINK_CYCLES(2), .STOP_ON_FAIL(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .o_run(run[1]), .i_running(running[1]),
      .i_passed(passed[1]), .o_done(done[1]), .o_all_passed(all_passed[1]),
      .o_pass_mask(pass_mask[1]), .o_timeout(timeout[1]), .o_fail_idx(fail_idx[1]),
      .o_led_r(led_r[1]), .o_led_g(led_g[1]), .o_led_b(led_b[1]));

   assign passed[0] = pcfg;
   assign passed[1] = pcfg;

   // Fixture model: raise running one cycle after run, hold 5 cycles, drop.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
               running[d][k] <= (mode[k] == M_IMM);
               fdone[d][k]   <= 1'b0;
               fcnt[d]       <= '0;
            end
         ever <= '0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            ever[d] <= ever[d] | run[d];
            for (int k = 0; k < 3; k++) begin
               if (!run[d][k])
                  running[d][k] <= (mode[k] == M_IMM) && !fdone[d][k];
               else if (mode[k] == M_NEVER || fdone[d][k])
                  running[d][k] <= 1'b0;
               else if (!running[d][k]) begin
                  running[d][k] <= 1'b1;
                  fcnt[d]       <= '0;
               end else if (fcnt[d] == 3'd4) begin
                  running[d][k] <= 1'b0;
                  fdone[d][k]   <= 1'b1;
               end else
                  fcnt[d] <= fcnt[d] + 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic set_cfg(input int m0, input int m1, input int m2, input logic [2:0] p);
      mode[0] = m0; mode[1] = m1; mode[2] = m2; pcfg = p;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic capture(input int d, input int n);
      for (int e = 1; e <= n; e++) begin
         @(negedge clk);
         trun[e]  = run[d];
         tmask[e] = pass_mask[d];
         tdone[e] = done[d];
         tledb[e] = led_b[d];
         tledg[e] = led_g[d];
         ttmo[e]  = timeout[d];
      end
   endtask

   task automatic run_to_done(input int d);
      int n = 0;
      while (!done[d] && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", d, done[d], 1);
   endtask

   task automatic blink_check(input int d, input int nb);
      int period = 4 * nb + 8;
      logic [31:0] act, exp;
      logic gb;
      act = '0; exp = '0; gb = 1'b0;
      for (int i = 0; i < 32; i++) begin
         act[i] = led_r[d];
         exp[i] = ((i % period) < 4 * nb) && (((i % period) % 4) < 2);
         gb     = gb | led_g[d] | led_b[d];
         @(negedge clk);
      end
      check("blink_r", d, act, exp);
      check("blink_gb_off", d, gb, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      set_cfg(M_NORM, M_NORM, M_NORM, 3'b111);
      //               stop m0      m1       m2      pcfg    all  mask    tmo  idx   ever
      vecs[0] = '{1'b1, M_NORM,  M_NORM,  M_NORM, 3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 3'b111};
      vecs[1] = '{1'b1, M_NORM,  M_NORM,  M_NORM, 3'b101, 1'b0, 3'b001, 1'b0, 2'd1, 3'b011};
      vecs[2] = '{1'b0, M_NEVER, M_NORM,  M_NORM, 3'b111, 1'b0, 3'b110, 1'b1, 2'd0, 3'b111};
      vecs[3] = '{1'b1, M_IMM,   M_NORM,  M_NORM, 3'b111, 1'b1, 3'b111, 1'b0, 2'd0, 3'b111};
      vecs[4] = '{1'b0, M_NORM,  M_NORM,  M_NORM, 3'b011, 1'b0, 3'b011, 1'b0, 2'd2, 3'b111};
      vecs[5] = '{1'b1, M_NORM,  M_NEVER, M_NORM, 3'b111, 1'b0, 3'b001, 1'b1, 2'd1, 3'b011};
      vecs[6] = '{1'b0, M_NORM,  M_NORM,  M_NORM, 3'b100, 1'b0, 3'b100, 1'b0, 2'd0, 3'b111};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_run", d, run[d], 0);
         check("rst_flags", d, {done[d], all_passed[d], timeout[d], fail_idx[d], pass_mask[d]}, 0);
         check("rst_leds", d, {led_r[d], led_g[d], led_b[d]}, 0);
      end

      // Outcome table
      for (int i = 0; i < 7; i++) begin
         int d;
         d = vecs[i].stop ? 0 : 1;
         rst_n = 1'b0;
         set_cfg(vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].pcfg);
         do_reset();
         run_to_done(d);
         check("all_passed", i, all_passed[d], vecs[i].exp_all);
         check("pass_mask", i, pass_mask[d], vecs[i].exp_mask);
         check("timeout", i, timeout[d], vecs[i].exp_tmo);
         check("fail_idx", i, fail_idx[d], vecs[i].exp_idx);
         check("runs_seen", i, ever[d], vecs[i].exp_ever);
         check("run_idle", i, run[d], 0);
         check("leds_rgb", i, {led_r[d], led_g[d], led_b[d]},
               vecs[i].exp_all ? 3'b010 : 3'b100);
      end

      // All-pass timeline: run 001/000/010/000/100/000 with one-cycle gaps
      rst_n = 1'b0;
      set_cfg(M_NORM, M_NORM, M_NORM, 3'b111);
      do_reset();
      capture(0, 30);
      check("t_wait_run", 4, trun[4], 3'b000);
      check("t_wait_ledb", 4, tledb[4], 0);
      check("t_arm0_run", 5, trun[5], 3'b001);
      check("t_arm0_ledb", 5, tledb[5], 1);
      check("t_busy0_run", 11, trun[11], 3'b001);
      check("t_mask_pre", 11, tmask[11], 3'b000);
      check("t_gap0_run", 12, trun[12], 3'b000);
      check("t_mask_post", 12, tmask[12], 3'b001);
      check("t_arm1_run", 13, trun[13], 3'b010);
      check("t_gap1_run", 20, trun[20], 3'b000);
      check("t_arm2_run", 21, trun[21], 3'b100);
      check("t_gap2_run", 28, trun[28], 3'b000);
      check("t_done_pre", 28, tdone[28], 0);
      check("t_done", 29, tdone[29], 1);
      check("t_green", 30, {tledg[30], tledb[30]}, 2'b10);

      // Immediate arm: running already high when ARM starts
      rst_n = 1'b0;
      set_cfg(M_IMM, M_NORM, M_NORM, 3'b111);
      do_reset();
      capture(0, 12);
      check("imm_arm", 5, trun[5], 3'b001);
      check("imm_busy_run", 10, {trun[10], tmask[10]}, {3'b001, 3'b000});
      check("imm_next", 11, {trun[11], tmask[11]}, {3'b000, 3'b001});
      check("imm_arm1", 12, trun[12], 3'b010);

      // Timeout on test 0 with run-all, then 1-blink code
      rst_n = 1'b0;
      set_cfg(M_NEVER, M_NORM, M_NORM, 3'b111);
      do_reset();
      capture(1, 21);
      check("tmo_pre", 20, {trun[20], ttmo[20]}, {3'b001, 1'b0});
      check("tmo_hit", 21, {trun[21], ttmo[21]}, {3'b000, 1'b1});
      run_to_done(1);
      check("tmo_idx", 1, fail_idx[1], 0);
      blink_check(1, 1);

      // Test 1 fails with halt-on-fail, then 2-blink code
      rst_n = 1'b0;
      set_cfg(M_NORM, M_NORM, M_NORM, 3'b101);
      do_reset();
      run_to_done(0);
      blink_check(0, 2);

      // Asynchronous reset during BUSY of test 1
      rst_n = 1'b0;
      set_cfg(M_NORM, M_NORM, M_NORM, 3'b111);
      do_reset();
      capture(0, 16);
      check("mid_busy1", 16, trun[16], 3'b010);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_run", 0, run[0], 0);
      check("mid_rst_leds", 0, {led_r[0], led_g[0], led_b[0]}, 0);
      check("mid_rst_mask", 0, pass_mask[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      capture(0, 5);
      check("re_wait", 4, {trun[4], tledb[4]}, {3'b000, 1'b0});
      check("re_arm0", 5, {trun[5], tledb[5]}, {3'b001, 1'b1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/test_runner.md
# test_runner

Parametrised on-board test sequencer for the Fomu physical test benches. It holds off for a start-up delay, then runs up to N_TESTS fixtures one after another through a run/running/passed handshake, and records a pass/fail result per fixture. It reports the outcome on the RGB LED drive lines: blue while running, solid green if all pass, and a red blink code naming the first failing fixture. A board top instantiates it between the clock buffer / SB_RGBA_DRV and the individual `*_test` fixtures.

## Interface
- `N_TESTS`, 4: number of fixtures, 1..16.
- `STARTUP_CYCLES`, 64: idle cycles after reset before the first test, ≥1.
- `TIMEOUT_CYCLES`, 2**20: per-test cycle budget, covering arm and busy phases.
- `BLINK_CYCLES`, 6_000_000: length of one blink on-phase or off-phase; 0.125 s at 48 MHz.
- `STOP_ON_FAIL`, 1: 1 = halt at first failure; 0 = run all tests.
- `i_clk` input 1: system clock.
- `i_rst_n` input 1: asynchronous active-low reset.
- `o_run` output N_TESTS: one-hot run level to fixture k.
- `i_running` input N_TESTS: fixture k busy.
- `i_passed` input N_TESTS: fixture k result, valid when its running is low.
- `o_done` output 1: sequence finished.
- `o_all_passed` output 1: every executed test passed; valid with o_done.
- `o_pass_mask` output N_TESTS: bit k set when test k passed.
- `o_timeout` output 1: first failure was a timeout.
- `o_fail_idx` output IDX_W: index of the first failing test. IDX_W = max(1, clog2(N_TESTS)).
- `o_led_r`, `o_led_g`, `o_led_b` output 1 each: PWM inputs for the LED driver.

## Operation
- **States:** WAIT → ARM → BUSY → NEXT → (ARM | DONE).
  - All outputs reset to 0 and the state resets to WAIT.
- **WAIT:** counts STARTUP_CYCLES, then goes to ARM with k=0.
- **ARM:**
  - o_run[k]=1, all other o_run bits 0.
  - Waits for i_running[k]=1, then goes to BUSY.
  - If i_running[k] is already high on entry, the transition happens on the first ARM cycle.
- **BUSY:**
  - o_run[k] stays 1.
  - When i_running[k]=0, sample i_passed[k] into o_pass_mask[k], then go to NEXT.
- **Timeout:**
  - A timeout counter clears on entry to ARM.
  - If it reaches TIMEOUT_CYCLES in ARM or BUSY, the test fails, pass_mask[k]=0, and the FSM goes to NEXT.
  - Timeout wins over a completion sampled in the same cycle.
- **NEXT:**
  - o_run drops to 0 for exactly one cycle.
  - On the first failure, latch o_fail_idx=k; also latch o_timeout if the failure was a timeout.
  - If k=N_TESTS-1, or a failure occurred and STOP_ON_FAIL=1, go to DONE. Otherwise k←k+1 and go to ARM.
- **DONE:**
  - o_done=1; o_all_passed = no failure recorded.
  - DONE is terminal until reset.
  - Tests that were not run have pass_mask=0 and do not count as failures for o_all_passed.
- **LEDs:**
  - WAIT: all LEDs off.
  - ARM, BUSY, NEXT: blue only.
  - DONE with all passed: green solid.
  - DONE with a failure: red blinks o_fail_idx+1 times, each blink BLINK_CYCLES on then BLINK_CYCLES off, followed by a 4×BLINK_CYCLES dark gap; the pattern repeats.
  - The red blink code starts at an on-phase on the first DONE cycle.
  - At most one LED line is high in any cycle.
- **Reset mid-operation:** immediate return to WAIT, all results cleared, o_run=0 asynchronously.

## Timing
- All outputs are registered; state changes are visible one cycle after the causing input.
- o_run[k] rises on the first ARM cycle, which is STARTUP_CYCLES+1 cycles after reset release.
- Completion latency: i_running[k] falls at cycle t → pass_mask[k] valid and o_run[k]=0 at t+1 → o_run[k+1]=1 at t+2.
- i_running and i_passed are synchronous to i_clk. The fixture must drop running in response to o_run low; it must not re-arm while o_run is low.
- Counter widths: clog2 of each count parameter +1. No wrap occurs in WAIT, the timeout counter, or the blink counters.

## Structure
- Put the state encodings (3-bit localparams), the gap multiplier (4), and the IDX_W computation in `test_runner_defs.vh`, shared by the board tops.
- One sub-module, `blink_code`: inputs i_clk, i_rst_n, i_en, i_count (IDX_W+1 bits); output o_led. It owns the blink phase and gap counters.

## Test plan
Bench parameters: N_TESTS=3, STARTUP_CYCLES=4, BLINK_CYCLES=2, TIMEOUT_CYCLES=16.
- **All pass:** each fixture model runs for 5 cycles with passed=1 → o_run one-hot 001, 010, 100 in order, each separated by a one-cycle gap; o_done=1, o_all_passed=1, o_pass_mask=111, green solid, red and blue 0.
- **Fail with stop:** test 1 ends with passed=0, STOP_ON_FAIL=1 → o_run[2] never asserted; o_pass_mask=001, o_fail_idx=1, o_timeout=0; red shows 2 blinks (2 cycles on, 2 off), then 8 dark cycles, repeating.
- **Timeout with STOP_ON_FAIL=0:** test 0 never raises running → after 16 ARM cycles o_timeout=1, o_fail_idx=0; tests 1 and 2 still run and pass; o_pass_mask=110, o_all_passed=0, red shows 1 blink per period.
- **Immediate arm:** i_running[0] is already high when ARM is entered → BUSY on the next cycle, and test 0 completes normally.
- **Reset mid-test:** assert i_rst_n=0 during BUSY of test 1 → o_run=0 and the LEDs go off without waiting for a clock edge. After release, the 4-cycle WAIT repeats and test 0 restarts.
